button_event_gen: RTL
=====================

# button_event_gen

Converts the debounced, clock-synchronous, active-high push-button level into one-cycle event pulses: press, release, short click, long press and auto-repeat. It sits directly downstream of the push-button debouncer and feeds the game control logic, for example cursor movement and shot confirmation, so that the controller never has to time raw button levels itself.

## Interface
- HOLD_CYCLES, default 50_000_000: cycles the button must stay down before `long_pulse` fires; must be ≥ 2.
- REPEAT_CYCLES, default 10_000_000: auto-repeat period after the long press; must be ≥ 1.
- CNT_W, default $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)+1): width of the internal counter.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous and active-high. One clock domain only.
- btn_stable  in  1  debounced button level, synchronous to clk, active-high.
- press_pulse  out  1  one-cycle pulse on a 0→1 transition of `btn_stable`.
- release_pulse  out  1  one-cycle pulse on a 1→0 transition of `btn_stable`.
- click_pulse  out  1  one-cycle pulse on a release that happens before the long-press threshold.
- long_pulse  out  1  one-cycle pulse when the hold time reaches HOLD_CYCLES.
- repeat_pulse  out  1  one-cycle pulse every REPEAT_CYCLES while held after the long press.
- held  out  1  level that is high from `long_pulse` until release.

## Operation
- All outputs are registered. Reset value of every output is 0. Reset state is IDLE with the counter at 0 and `btn_prev` at 0.
- State machine has three states: IDLE, DOWN and HELD.
  - IDLE→DOWN when `btn_stable`=1. Asserts `press_pulse`; the counter is cleared.
  - DOWN: the counter increments each cycle while `btn_stable`=1.
    - When the counter reaches HOLD_CYCLES-1: go to HELD, assert `long_pulse`, set `held`, clear the counter.
  - DOWN→IDLE when `btn_stable`=0. Asserts `release_pulse` and `click_pulse`.
  - HELD: the counter increments.
    - When the counter reaches REPEAT_CYCLES-1: assert `repeat_pulse` and clear the counter.
  - HELD→IDLE when `btn_stable`=0. Asserts `release_pulse` only (no `click_pulse`) and clears `held`.
- Release takes priority: if `btn_stable` is sampled 0 on the same edge the counter hits a terminal value, the block takes the release transition and suppresses `long_pulse`/`repeat_pulse`.
- The counter never wraps. It is cleared at every terminal count and on every state change.
- Any mid-operation `rst` immediately forces IDLE and all outputs to 0. A button still held when `rst` is released produces a fresh `press_pulse` on the first edge after reset.

## Timing
- Latency is 1 cycle. If `btn_stable` is first sampled 1 at edge k, `press_pulse` is high from edge k to edge k+1.
- `long_pulse` is high after edge k+HOLD_CYCLES, provided `btn_stable` stayed 1 through that edge.
- `repeat_pulse` is high after edges k+HOLD_CYCLES+n·REPEAT_CYCLES, for n ≥ 1.
- If `btn_stable` is first sampled 0 at edge m, `release_pulse` (and `click_pulse` if in DOWN) is high after edge m.
- A press lasting a single cycle produces `press_pulse` then `release_pulse`/`click_pulse` on consecutive cycles.
- At most one of `press_pulse`, `release_pulse`, `long_pulse`, `repeat_pulse` is high in any cycle. `click_pulse` only coincides with `release_pulse`.

## Configuration
- BTN_AUTOREPEAT_EN defined: HELD behaves as described and generates repeats.
- BTN_AUTOREPEAT_EN undefined:
  - `repeat_pulse` is tied to 0.
  - In HELD the counter holds at 0 and the REPEAT logic is not synthesised.
  - All other behaviour is unchanged.

## Structure
- Shared package `btn_pkg` holds:
  - the `btn_state_t` enum (IDLE, DOWN, HELD);
  - the default HOLD/REPEAT constants for the 50 MHz board clock.
- One sub-module, `btn_hold_timer`, is natural. It is a clearable up-counter with two terminal-compare flags (hold terminal, repeat terminal) driven by the FSM's clear/enable signals.

## Test plan
All scenarios use HOLD_CYCLES=8 and REPEAT_CYCLES=4 unless stated.
- Reset with `btn_stable`=1 held → all outputs 0 during reset; `press_pulse` on the first edge after `rst` falls.
- High for 3 cycles, then low → `press_pulse` at k, `release_pulse`+`click_pulse` at k+3; no `long_pulse`; `held` stays 0.
- High for 20 cycles →
  - `press_pulse` at k, `long_pulse` at k+8, `repeat_pulse` at k+12 and k+16;
  - `release_pulse` at k+20 with no `click_pulse`; `held` high over k+8..k+20.
- Release sampled exactly at edge k+8 → `release_pulse`+`click_pulse`; `long_pulse` never asserted.
- `rst` pulsed at k+10 during HELD → outputs 0 immediately; after `rst` falls with `btn_stable` still 1, a fresh `press_pulse` and `long_pulse` 8 cycles later.
- Build without BTN_AUTOREPEAT_EN, high for 20 cycles → `long_pulse` at k+8 and no `repeat_pulse` at any time.

Source files
------------

// File: rtl/btn_pkg.sv
// btn_pkg: shared types and constants for the button event generator.
//   btn_state_t        : FSM state encoding (IDLE, DOWN, HELD)
//   BTN_HOLD_DEFAULT   : long-press threshold, 1 s at the 50 MHz board clock
//   BTN_REPEAT_DEFAULT : auto-repeat period, 200 ms at the 50 MHz board clock
//   btn_max()          : helper used to size the hold/repeat counter
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DOWN = 2'd1,
    HELD = 2'd2
  } btn_state_t;

  localparam int BTN_HOLD_DEFAULT   = 50_000_000;
  localparam int BTN_REPEAT_DEFAULT = 10_000_000;

  function automatic int btn_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_gen_if.sv
// button_event_gen_if: groups the debounced button level and the event
// outputs of button_event_gen.
//   btn_stable    : debounced button level (driven by master)
//   press_pulse   : one-cycle pulse on press
//   release_pulse : one-cycle pulse on release
//   click_pulse   : one-cycle pulse on release before the long-press time
//   long_pulse    : one-cycle pulse when the long-press time is reached
//   repeat_pulse  : one-cycle auto-repeat pulse while held
//   held          : level, high from long_pulse until release
// Modports: master = button source / event consumer, slave = event generator.
interface button_event_gen_if;

  logic btn_stable;
  logic press_pulse;
  logic release_pulse;
  logic click_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic held;

  modport master (
    output btn_stable,
    input  press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held
  );

  modport slave (
    input  btn_stable,
    output press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held
  );

endinterface

// File: rtl/btn_hold_timer.sv
// btn_hold_timer: clearable up-counter with terminal-compare flags for the
// long-press and auto-repeat thresholds.
//   clk, rst   : system clock, async active-high reset
//   i_clr      : clear counter to 0 (wins over i_en)
//   i_en       : increment counter
//   o_hold_tc  : counter == HOLD_CYCLES-1
//   o_rep_tc   : counter == REPEAT_CYCLES-1 (only with BTN_AUTOREPEAT_EN)
// Macro BTN_AUTOREPEAT_EN: when undefined the repeat compare is not built.
module btn_hold_timer #(
  parameter int HOLD_CYCLES   = 8,
`ifdef BTN_AUTOREPEAT_EN
  parameter int REPEAT_CYCLES = 4,
`endif
  parameter int CNT_W         = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
`ifdef BTN_AUTOREPEAT_EN
  output logic o_rep_tc,
`endif
  output logic o_hold_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_hold_tc = (r_cnt == CNT_W'(HOLD_CYCLES - 1));

`ifdef BTN_AUTOREPEAT_EN
  assign o_rep_tc = (r_cnt == CNT_W'(REPEAT_CYCLES - 1));
`endif

endmodule

// File: rtl/button_event_gen.sv
// button_event_gen: turns the debounced button level into one-cycle press,
// release, click, long-press and auto-repeat pulses plus a 'held' level.
//   clk, rst : system clock, async active-high reset
//   bus      : button_event_gen_if.slave (btn_stable in, event outputs out)
// Parameters: HOLD_CYCLES (>= 2), REPEAT_CYCLES (>= 1), CNT_W.
// Macro BTN_AUTOREPEAT_EN: defined -> auto-repeat in HELD; undefined ->
// repeat_pulse tied 0 and the counter parks at 0 while HELD.
//
// state | meaning
// IDLE  | button up, waiting for a press
// DOWN  | button down, timing towards the long-press threshold
// HELD  | long press reached, auto-repeating until release
module button_event_gen
  import btn_pkg::*;
#(
  parameter int HOLD_CYCLES   = BTN_HOLD_DEFAULT,
  parameter int REPEAT_CYCLES = BTN_REPEAT_DEFAULT,
  parameter int CNT_W         = $clog2(btn_max(HOLD_CYCLES, REPEAT_CYCLES) + 1)
) (
  input  logic               clk,
  input  logic               rst,
  button_event_gen_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_DOWN = 2'(DOWN);
  localparam logic [1:0] ST_HELD = 2'(HELD);

  logic [1:0] r_state;
  logic       r_btn_prev;
  logic       r_press;
  logic       r_release;
  logic       r_click;
  logic       r_long;
  logic       r_repeat;
  logic       r_held;

  logic w_rise;
  logic w_fall;
  logic w_clr;
  logic w_en;
  logic w_hold_tc;
`ifdef BTN_AUTOREPEAT_EN
  logic w_rep_tc;
`endif

  assign w_rise = bus.btn_stable & ~r_btn_prev;
  assign w_fall = ~bus.btn_stable & r_btn_prev;

  // Counter is held clear in IDLE so DOWN always starts from 0, and is
  // cleared on every terminal count and every exit from DOWN/HELD.
  always_comb begin
    w_clr = 1'b1;
    w_en  = 1'b0;
    case (r_state)
      ST_DOWN: begin
        w_en  = 1'b1;
        w_clr = w_fall | w_hold_tc;
      end
      ST_HELD: begin
`ifdef BTN_AUTOREPEAT_EN
        w_en  = 1'b1;
        w_clr = w_fall | w_rep_tc;
`else
        w_clr = 1'b1;
`endif
      end
      default: begin
      end
    endcase
  end

  btn_hold_timer #(
    .HOLD_CYCLES   (HOLD_CYCLES),
`ifdef BTN_AUTOREPEAT_EN
    .REPEAT_CYCLES (REPEAT_CYCLES),
`endif
    .CNT_W         (CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_clr),
    .i_en      (w_en),
`ifdef BTN_AUTOREPEAT_EN
    .o_rep_tc  (w_rep_tc),
`endif
    .o_hold_tc (w_hold_tc)
  );

  // Release is tested before the terminal flags so a release landing on a
  // terminal edge suppresses long/repeat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_btn_prev <= 1'b0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_click    <= 1'b0;
      r_long     <= 1'b0;
      r_repeat   <= 1'b0;
      r_held     <= 1'b0;
    end else begin
      r_btn_prev <= bus.btn_stable;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_click    <= 1'b0;
      r_long     <= 1'b0;
      r_repeat   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_state <= ST_DOWN;
            r_press <= 1'b1;
          end
        end
        ST_DOWN: begin
          if (w_fall) begin
            r_state   <= ST_IDLE;
            r_release <= 1'b1;
            r_click   <= 1'b1;
          end else if (w_hold_tc) begin
            r_state <= ST_HELD;
            r_long  <= 1'b1;
            r_held  <= 1'b1;
          end
        end
        ST_HELD: begin
          if (w_fall) begin
            r_state   <= ST_IDLE;
            r_release <= 1'b1;
            r_held    <= 1'b0;
          end
`ifdef BTN_AUTOREPEAT_EN
          else if (w_rep_tc) begin
            r_repeat <= 1'b1;
          end
`endif
        end
        default: begin
          r_state <= ST_IDLE;
          r_held  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.press_pulse   = r_press;
  assign bus.release_pulse = r_release;
  assign bus.click_pulse   = r_click;
  assign bus.long_pulse    = r_long;
  assign bus.repeat_pulse  = r_repeat;
  assign bus.held          = r_held;

endmodule
